prime_nearest_bcd: RTL and testbench

// - Downstream consumer of the up/low prime search stage. Captures {Intake, UpPrime, LowPrime}
//   on each completed search, picks the prime nearest to Intake, and converts it to 4-digit BCD
//   for the display stage.
// - Sequential double-dabble conversion; result is held under a valid/ready handshake.

---
 rtl/prime_nearest_bcd.sv | 219 +++++++++++++++++++++
 tb/tb_prime_nearest_bcd.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/prime_nearest_bcd.sv
// Picks the prime nearest to the requested intake and converts it to packed BCD
// with a sequential double-dabble. Optional feature macro: PRIME_GAP_EN (exports up-low gap).
module prime_nearest_bcd #(
    parameter int W      = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [W-1:0]        intake,
    input  logic [W-1:0]        up_prime,
    input  logic [W-1:0]        low_prime,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [W-1:0]        near_bin,
    output logic [4*DIGITS-1:0] near_bcd,
    output logic                tie,
    output logic                err,
    output logic                overrun,
    output logic [W-1:0]        gap
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + W;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_CONVERT,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               in_valid_q;
    logic [W-1:0]       intake_q, intake_d;
    logic [W-1:0]       up_q, up_d;
    logic [W-1:0]       low_q, low_d;
    logic [W-1:0]       near_sel_q, near_sel_d;
    logic               tie_sel_q, tie_sel_d;
    logic               err_sel_q, err_sel_d;
    logic [SR_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       near_bin_q, near_bin_d;
    logic [BCD_W-1:0]   near_bcd_q, near_bcd_d;
    logic               tie_q, tie_d;
    logic               err_q, err_d;
    logic               overrun_q, overrun_d;
`ifdef PRIME_GAP_EN
    logic [W-1:0]       gap_sel_q, gap_sel_d;
    logic [W-1:0]       gap_q, gap_d;
`endif

    logic               cap;
    logic [W-1:0]       du, dl;
    logic               sel_err;
    logic               sel_tie;
    logic [W-1:0]       sel_near;
    logic [SR_W-1:0]    sr_shift;
    logic               last_iter;

    assign cap = in_valid & ~in_valid_q;

    // Distances are only meaningful when the inputs are consistent; err masks them.
    assign du       = up_q - intake_q;
    assign dl       = intake_q - low_q;
    assign sel_err  = (up_q <= intake_q) || (low_q >= intake_q);
    assign sel_tie  = !sel_err && (du == dl);
    assign sel_near = sel_err ? '0 : ((du < dl) ? up_q : low_q);

    assign last_iter = (cnt_q == CNT_W'(W - 1));

    // One double-dabble step: add 3 to each nibble >= 5, then shift left by one.
    assign sr_shift[0]   = 1'b0;
    assign sr_shift[W:1] = shift_q[W-1:0];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
        logic [3:0] nib;
        assign nib = shift_q[W+4*gi +: 4];
        if (gi == DIGITS - 1) begin : g_top
            // The carry out of the top digit falls off the register; only 3 bits survive.
            assign sr_shift[SR_W-1 -: 3] = (nib >= 4'd5) ? 3'(nib[2:0] + 3'd3) : nib[2:0];
        end else begin : g_mid
            assign sr_shift[W+1+4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    end

    always_comb begin
        state_d     = state_q;
        intake_d    = intake_q;
        up_d        = up_q;
        low_d       = low_q;
        near_sel_d  = near_sel_q;
        tie_sel_d   = tie_sel_q;
        err_sel_d   = err_sel_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        near_bin_d  = near_bin_q;
        near_bcd_d  = near_bcd_q;
        tie_d       = tie_q;
        err_d       = err_q;
        overrun_d   = overrun_q;
`ifdef PRIME_GAP_EN
        gap_sel_d   = gap_sel_q;
        gap_d       = gap_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cap) begin
                    intake_d  = intake;
                    up_d      = up_prime;
                    low_d     = low_prime;
                    overrun_d = 1'b0;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                near_sel_d = sel_near;
                tie_sel_d  = sel_tie;
                err_sel_d  = sel_err;
                shift_d    = {{BCD_W{1'b0}}, sel_near};
                cnt_d      = '0;
`ifdef PRIME_GAP_EN
                gap_sel_d  = sel_err ? '0 : (up_q - low_q);
`endif
                state_d    = S_CONVERT;
            end
            S_CONVERT: begin
                shift_d = sr_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    near_bcd_d  = sr_shift[SR_W-1 -: BCD_W];
                    near_bin_d  = near_sel_q;
                    tie_d       = tie_sel_q;
                    err_d       = err_sel_q;
                    out_valid_d = 1'b1;
`ifdef PRIME_GAP_EN
                    gap_d       = gap_sel_q;
`endif
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new search finishing while we are still busy is dropped but remembered.
        if (cap && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_valid_q  <= 1'b0;
            intake_q    <= '0;
            up_q        <= '0;
            low_q       <= '0;
            near_sel_q  <= '0;
            tie_sel_q   <= 1'b0;
            err_sel_q   <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            near_bin_q  <= '0;
            near_bcd_q  <= '0;
            tie_q       <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PRIME_GAP_EN
            gap_sel_q   <= '0;
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_valid_q  <= in_valid;
            intake_q    <= intake_d;
            up_q        <= up_d;
            low_q       <= low_d;
            near_sel_q  <= near_sel_d;
            tie_sel_q   <= tie_sel_d;
            err_sel_q   <= err_sel_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            near_bin_q  <= near_bin_d;
            near_bcd_q  <= near_bcd_d;
            tie_q       <= tie_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
`ifdef PRIME_GAP_EN
            gap_sel_q   <= gap_sel_d;
            gap_q       <= gap_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign near_bin  = near_bin_q;
    assign near_bcd  = near_bcd_q;
    assign tie       = tie_q;
    assign err       = err_q;
    assign overrun   = overrun_q;
`ifdef PRIME_GAP_EN
    assign gap       = gap_q;
`else
    assign gap       = '0;
`endif

endmodule

// File: tb/tb_prime_nearest_bcd.sv
// Directed bench for prime_nearest_bcd: nearest-prime selection, BCD conversion,
// latency, hold/accept, overrun and asynchronous reset behaviour.
module tb_prime_nearest_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [13:0] intake;
    logic [13:0] up_prime;
    logic [13:0] low_prime;
    logic        out_ready;
    logic        out_valid;
    logic [13:0] near_bin;
    logic [15:0] near_bcd;
    logic        tie;
    logic        err;
    logic        overrun;
    logic [13:0] gap;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    prime_nearest_bcd #(.W(14), .DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .intake    (intake),
        .up_prime  (up_prime),
        .low_prime (low_prime),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .near_bin  (near_bin),
        .near_bcd  (near_bcd),
        .tie       (tie),
        .err       (err),
        .overrun   (overrun),
        .gap       (gap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise in_valid for one cycle; returns just after the edge that samples the capture.
    task automatic launch(input int i, input int u, input int l);
        intake    = 14'(i);
        up_prime  = 14'(u);
        low_prime = 14'(l);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_drops_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_result(input string tag, input int lat_exp, input int bin_exp,
                                input int bcd_exp, input int tie_exp, input int err_exp,
                                input int gap_exp);
        chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_bin"}, 32'(near_bin), 32'(bin_exp));
        chk({tag, "_bcd"}, 32'(near_bcd), 32'(bcd_exp));
        chk({tag, "_tie"}, 32'(tie), 32'(tie_exp));
        chk({tag, "_err"}, 32'(err), 32'(err_exp));
`ifdef PRIME_GAP_EN
        chk({tag, "_gap"}, 32'(gap), 32'(gap_exp));
`else
        chk({tag, "_gap"}, 32'(gap), 32'd0);
        if (gap_exp < 0) $display("unexpected gap argument");
`endif
        $display("txn %s: intake=%0d up=%0d low=%0d -> bin=%0d bcd=%h tie=%0b err=%0b gap=%0d lat=%0d",
                 tag, intake, up_prime, low_prime, near_bin, near_bcd, tie, err, gap, lat);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        intake    = '0;
        up_prime  = '0;
        low_prime = '0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_bin", 32'(near_bin), 32'd0);
        chk("rst_bcd", 32'(near_bcd), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_gap", 32'(gap), 32'd0);
        reset = 1'b0;
        tick();

        // Nearest is the upper prime; then hold with out_ready low for 10 cycles.
        launch(100, 101, 97);
        chk("t1_not_valid_early", 32'(out_valid), 32'd0);
        wait_valid(lat);
        check_result("t1", 15, 101, 'h0101, 0, 0, 4);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_bcd", 32'(near_bcd), 32'h0101);
        end
        accept();
        chk("t1_bin_retained", 32'(near_bin), 32'd101);
        chk("t1_bcd_retained", 32'(near_bcd), 32'h0101);

        // Top of range.
        launch(9972, 9973, 9967);
        wait_valid(lat);
        check_result("t2", 15, 9973, 'h9973, 0, 0, 6);
        accept();

        // Asynchronous reset mid-CONVERT clears outputs without waiting for a clock edge.
        launch(100, 101, 97);
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_bin", 32'(near_bin), 32'd0);
        chk("midrst_bcd", 32'(near_bcd), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        launch(100, 101, 97);
        wait_valid(lat);
        check_result("t3_after_rst", 15, 101, 'h0101, 0, 0, 4);
        accept();

        // Tie case with a second in_valid edge arriving during CONVERT.
        launch(4, 5, 3);
        for (int k = 0; k < 4; k++) tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_valid(lat);
        check_result("t4_tie", 10, 3, 'h0003, 1, 0, 2);
        chk("overrun_held", 32'(overrun), 32'd1);
        accept();

        // Inconsistent inputs; the capture itself clears overrun.
        launch(50, 53, 50);
        chk("overrun_cleared", 32'(overrun), 32'd0);
        wait_valid(lat);
        check_result("t5_err", 15, 0, 'h0000, 0, 1, 0);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
